// File: rtl/onewire_master.sv
// Standard-speed 1-Wire bit master driving the control side of a pad IOBUF.
// Executes one reset, write or read slot per accepted command.
module onewire_master #(
    parameter int unsigned CLK_PER_US = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd,
    input  logic       wr_bit,
    output logic       rsp_valid,
    output logic       rsp_bit,
    output logic       busy,
    output logic       io_i,
    output logic       io_t,
    input  logic       io_o
);

    localparam int PW = $clog2(CLK_PER_US);
    localparam int UW = 9;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_PER_US - 1);

    localparam logic [1:0] CMD_RST = 2'b00;
    localparam logic [1:0] CMD_WR  = 2'b01;
    localparam logic [1:0] CMD_RD  = 2'b10;
    localparam logic [1:0] CMD_NOP = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOW,
        S_REL,
        S_REC
    } state_t;

    state_t          state_q;
    logic [PW-1:0]   pre_q;
    logic [UW-1:0]   us_q;
    logic [1:0]      cmd_q;
    logic            wr_q;
    logic            res_q;
    logic            io_t_q;
    logic            ready_q;
    logic            busy_q;
    logic            rsp_valid_q;
    logic            rsp_bit_q;
    logic [1:0]      sync_q;

    logic [UW-1:0]   phase_us_d;
    logic            tick_d;
    logic            phase_end_d;
    logic            sample_d;

    assign io_i      = 1'b0;
    assign io_t      = io_t_q;
    assign cmd_ready = ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_bit   = rsp_bit_q;

    // Two-flop synchroniser on the pad input; idles high like the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], io_o};
        end
    end

    // Length of the current phase in microseconds and end-of-phase detect.
    always_comb begin
        phase_us_d = 9'd1;
        unique case (state_q)
            S_IDLE: phase_us_d = 9'd1;
            S_LOW: begin
                if (cmd_q == CMD_RST)     phase_us_d = 9'd480;
                else if (cmd_q == CMD_RD) phase_us_d = 9'd6;
                else if (wr_q)            phase_us_d = 9'd6;
                else                      phase_us_d = 9'd60;
            end
            S_REL: begin
                if (cmd_q == CMD_RST)     phase_us_d = 9'd70;
                else if (cmd_q == CMD_RD) phase_us_d = 9'd9;
                else if (wr_q)            phase_us_d = 9'd64;
                else                      phase_us_d = 9'd10;
            end
            S_REC: begin
                if (cmd_q == CMD_RST)     phase_us_d = 9'd410;
                else                      phase_us_d = 9'd55;
            end
        endcase
        tick_d      = (pre_q == PRE_LAST);
        phase_end_d = tick_d && (us_q == phase_us_d - 9'd1);
        // Presence is an active-low answer, read data is taken as-is.
        sample_d    = (cmd_q == CMD_RST) ? ~sync_q[1] : sync_q[1];
    end

    // Slot sequencer with registered pad control and handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pre_q       <= '0;
            us_q        <= '0;
            cmd_q       <= CMD_RST;
            wr_q        <= 1'b0;
            res_q       <= 1'b0;
            io_t_q      <= 1'b1;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_bit_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (state_q == S_IDLE || phase_end_d) begin
                pre_q <= '0;
                us_q  <= '0;
            end else if (tick_d) begin
                pre_q <= '0;
                us_q  <= us_q + 9'd1;
            end else begin
                pre_q <= pre_q + PW'(1);
            end
            unique case (state_q)
                S_IDLE: begin
                    // The reserved code is swallowed without touching the bus.
                    if (cmd_valid && cmd != CMD_NOP) begin
                        cmd_q   <= cmd;
                        wr_q    <= wr_bit;
                        state_q <= S_LOW;
                        io_t_q  <= 1'b0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                S_LOW: begin
                    if (phase_end_d) begin
                        state_q <= S_REL;
                        io_t_q  <= 1'b1;
                    end
                end
                S_REL: begin
                    if (phase_end_d) begin
                        if (cmd_q == CMD_WR) begin
                            state_q     <= S_IDLE;
                            ready_q     <= 1'b1;
                            busy_q      <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            rsp_bit_q   <= wr_q;
                        end else begin
                            res_q   <= sample_d;
                            state_q <= S_REC;
                        end
                    end
                end
                S_REC: begin
                    if (phase_end_d) begin
                        state_q     <= S_IDLE;
                        ready_q     <= 1'b1;
                        busy_q      <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_bit_q   <= res_q;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_onewire_master.sv
// Self-checking bench for onewire_master with a simple slave bus model.
// Expected responses are queued at stimulus time and popped on rsp_valid.
module tb_onewire_master;

    localparam int CPU = 4;

    typedef struct {
        bit b;
        int lat;
        int low;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd = 2'b00;
    logic       wr_bit = 1'b0;
    logic       rsp_valid;
    logic       rsp_bit;
    logic       busy;
    logic       io_i;
    logic       io_t;
    logic       io_o;

    int ncmp = 0;
    int nfail = 0;

    int   mode = 0;
    int   rel_cnt = 0;
    int   slot_cnt = 100000;
    logic prev_t = 1'b1;
    logic slave_low;

    int   cyc = 0;
    int   lowcnt = 0;
    int   rsp_cnt = 0;
    int   acc_q[$];
    int   rsp_cyc_q[$];
    int   low_q[$];
    bit   rspb_q[$];
    exp_t exp_q[$];

    onewire_master #(.CLK_PER_US(CPU)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd       (cmd),
        .wr_bit    (wr_bit),
        .rsp_valid (rsp_valid),
        .rsp_bit   (rsp_bit),
        .busy      (busy),
        .io_i      (io_i),
        .io_t      (io_t),
        .io_o      (io_o)
    );

    always #5 clk = ~clk;

    // Slave model: mode 1 answers presence, mode 2 holds a read slot low.
    assign slave_low = (mode == 1 && rel_cnt >= 15 * CPU && rel_cnt < 120 * CPU)
                    || (mode == 2 && slot_cnt < 30 * CPU);
    assign io_o = io_t & ~slave_low;

    always @(negedge clk) begin
        prev_t   <= io_t;
        rel_cnt  <= io_t ? rel_cnt + 1 : 0;
        slot_cnt <= (!io_t && prev_t) ? 0 : slot_cnt + 1;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Records accepts, low-pulse widths and responses for the tests.
    always @(negedge clk) begin
        if (rst) begin
            lowcnt <= 0;
            acc_q.delete();
        end else begin
            if (!io_t) lowcnt <= lowcnt + 1;
            else if (lowcnt != 0) begin
                low_q.push_back(lowcnt);
                lowcnt <= 0;
            end
            if (cmd_valid && cmd_ready && cmd != 2'b11) acc_q.push_back(cyc);
            if (rsp_valid) begin
                rsp_cyc_q.push_back(cyc);
                rspb_q.push_back(rsp_bit);
                rsp_cnt <= rsp_cnt + 1;
            end
        end
    end

    task automatic send(input logic [1:0] c, input logic w);
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd = c;
        wr_bit = w;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (cmd_ready) break;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (rsp_cyc_q.size() >= n && low_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic flush();
        exp_q.delete();
        acc_q.delete();
        rsp_cyc_q.delete();
        rspb_q.delete();
        low_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        ncmp++; if (io_t !== 1'b1) begin nfail++; $display("FAIL rst_io_t: got %b want 1", io_t); end
        ncmp++; if (io_i !== 1'b0) begin nfail++; $display("FAIL rst_io_i: got %b want 0", io_i); end
        ncmp++; if (cmd_ready !== 1'b1) begin nfail++; $display("FAIL rst_ready: got %b want 1", cmd_ready); end
        ncmp++; if (busy !== 1'b0) begin nfail++; $display("FAIL rst_busy: got %b want 0", busy); end
        ncmp++; if (rsp_valid !== 1'b0) begin nfail++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
        ncmp++; if (rsp_bit !== 1'b0) begin nfail++; $display("FAIL rst_rsp_bit: got %b want 0", rsp_bit); end
    endtask

    task automatic test_bus_reset();
        bit ok;
        exp_t e;
        int a, r, lw;
        bit b;
        for (int s = 0; s < 2; s++) begin
            mode = (s == 0) ? 1 : 0;
            exp_q.push_back('{b: (s == 0), lat: 1 + 960 * CPU, low: 480 * CPU});
            send(2'b00, 1'b0);
            wait_rsp(1, 5000, ok);
            ncmp++;
            if (!ok) begin
                nfail++;
                $display("FAIL busrst%0d_timeout: got no rsp_valid want one", s);
                flush();
            end else begin
                e = exp_q.pop_front();
                a = acc_q.pop_front();
                r = rsp_cyc_q.pop_front();
                b = rspb_q.pop_front();
                lw = low_q.pop_front();
                ncmp++; if (b !== e.b) begin nfail++; $display("FAIL busrst%0d_presence: got %0d want %0d", s, b, e.b); end
                ncmp++; if (r - a != e.lat) begin nfail++; $display("FAIL busrst%0d_latency: got %0d want %0d", s, r - a, e.lat); end
                ncmp++; if (lw != e.low) begin nfail++; $display("FAIL busrst%0d_low: got %0d want %0d", s, lw, e.low); end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        exp_t e;
        int a, r, lw;
        bit b;
        mode = 0;
        exp_q.push_back('{b: 1'b0, lat: 1 + 70 * CPU, low: 60 * CPU});
        exp_q.push_back('{b: 1'b1, lat: 1 + 70 * CPU, low: 6 * CPU});
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd = 2'b01;
        wr_bit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (acc_q.size() >= 1) break;
        end
        @(posedge clk); #1;
        wr_bit = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk); #1;
            if (acc_q.size() >= 2) break;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_rsp(2, 1000, ok);
        ncmp++;
        if (!ok || acc_q.size() < 2) begin
            nfail++;
            $display("FAIL b2b_timeout: got %0d rsp want 2", rsp_cyc_q.size());
            flush();
        end else begin
            ncmp++;
            if (acc_q[1] != rsp_cyc_q[0]) begin
                nfail++;
                $display("FAIL b2b_accept_cycle: got %0d want %0d", acc_q[1], rsp_cyc_q[0]);
            end
            for (int k = 0; k < 2; k++) begin
                e = exp_q.pop_front();
                a = acc_q.pop_front();
                r = rsp_cyc_q.pop_front();
                b = rspb_q.pop_front();
                lw = low_q.pop_front();
                ncmp++; if (b !== e.b) begin nfail++; $display("FAIL b2b%0d_echo: got %0d want %0d", k, b, e.b); end
                ncmp++; if (r - a != e.lat) begin nfail++; $display("FAIL b2b%0d_latency: got %0d want %0d", k, r - a, e.lat); end
                ncmp++; if (lw != e.low) begin nfail++; $display("FAIL b2b%0d_low: got %0d want %0d", k, lw, e.low); end
            end
        end
    endtask

    task automatic test_read(input string tag, input int md, input bit want);
        bit ok;
        exp_t e;
        int a, r, lw;
        bit b;
        mode = md;
        exp_q.push_back('{b: want, lat: 1 + 70 * CPU, low: 6 * CPU});
        send(2'b10, 1'b0);
        wait_rsp(1, 1000, ok);
        ncmp++;
        if (!ok) begin
            nfail++;
            $display("FAIL %s_timeout: got no rsp_valid want one", tag);
            flush();
        end else begin
            e = exp_q.pop_front();
            a = acc_q.pop_front();
            r = rsp_cyc_q.pop_front();
            b = rspb_q.pop_front();
            lw = low_q.pop_front();
            ncmp++; if (b !== e.b) begin nfail++; $display("FAIL %s_bit: got %0d want %0d", tag, b, e.b); end
            ncmp++; if (r - a != e.lat) begin nfail++; $display("FAIL %s_latency: got %0d want %0d", tag, r - a, e.lat); end
            ncmp++; if (lw != e.low) begin nfail++; $display("FAIL %s_low: got %0d want %0d", tag, lw, e.low); end
        end
        mode = 0;
    endtask

    task automatic test_reserved();
        int r0;
        int lows;
        int busys;
        r0 = rsp_cnt;
        lows = 0;
        busys = 0;
        send(2'b11, 1'b0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (io_t !== 1'b1) lows++;
            if (busy !== 1'b0) busys++;
        end
        ncmp++; if (lows != 0) begin nfail++; $display("FAIL nop_io_t: got %0d low cycles want 0", lows); end
        ncmp++; if (busys != 0) begin nfail++; $display("FAIL nop_busy: got %0d busy cycles want 0", busys); end
        ncmp++; if (rsp_cnt != r0) begin nfail++; $display("FAIL nop_rsp: got %0d pulses want 0", rsp_cnt - r0); end
    endtask

    task automatic test_rst_mid();
        int r0;
        mode = 1;
        r0 = rsp_cnt;
        send(2'b00, 1'b0);
        repeat (100 * CPU) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        ncmp++; if (io_t !== 1'b1) begin nfail++; $display("FAIL midrst_async_io_t: got %b want 1", io_t); end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        mode = 0;
        @(negedge clk);
        ncmp++; if (cmd_ready !== 1'b1) begin nfail++; $display("FAIL midrst_ready: got %b want 1", cmd_ready); end
        repeat (1000) @(negedge clk);
        ncmp++; if (rsp_cnt != r0) begin nfail++; $display("FAIL midrst_rsp: got %0d pulses want 0", rsp_cnt - r0); end
        flush();
        test_read("midrst_read", 2, 1'b0);
    endtask

    initial begin
        test_reset();
        test_bus_reset();
        test_back_to_back();
        test_read("read0", 2, 1'b0);
        test_read("read1", 0, 1'b1);
        test_reserved();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
